// File: rtl/vscale_fetch_queue_if.sv
// Fetch-queue bundle: imem request/response, DX dequeue handshake and ctrl redirect.
// master = fetch queue, slave = core/memory side.
interface vscale_fetch_queue_if #(
    parameter int unsigned XPR_LEN = 32,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic               redirect;
    logic [XPR_LEN-1:0] redirect_pc;
    logic               imem_req;
    logic [XPR_LEN-1:0] imem_addr;
    logic               imem_wait;
    logic [XPR_LEN-1:0] imem_rdata;
    logic               imem_badmem_e;
    logic               deq_valid;
    logic               deq_ready;
    logic [XPR_LEN-1:0] deq_pc;
    logic [XPR_LEN-1:0] deq_inst;
    logic               deq_badmem;
    logic [OccW-1:0]    occupancy;

    modport master (
        input  redirect, redirect_pc, imem_wait, imem_rdata, imem_badmem_e, deq_ready,
        output imem_req, imem_addr, deq_valid, deq_pc, deq_inst, deq_badmem, occupancy
    );

    modport slave (
        output redirect, redirect_pc, imem_wait, imem_rdata, imem_badmem_e, deq_ready,
        input  imem_req, imem_addr, deq_valid, deq_pc, deq_inst, deq_badmem, occupancy
    );
endinterface

// File: rtl/vscale_fetch_queue.sv
// Decoupled instruction fetch: sequential PC generation, credit-limited imem requests and a
// DEPTH-entry queue towards DX. Define VSCALE_FETCH_BYPASS_EN for a 1-cycle empty-queue bypass.
module vscale_fetch_queue #(
    parameter int unsigned        XPR_LEN  = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [XPR_LEN-1:0] RESET_PC = 'h200
) (
    input logic                  clk,
    input logic                  reset,
    vscale_fetch_queue_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

    typedef logic [XPR_LEN-1:0] word_t;

    word_t            fetch_pc_q, fetch_pc_d;
    word_t            pc_pending_q, pc_pending_d;
    logic             resp_pending_q, resp_pending_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;

    word_t            pc_mem   [DEPTH];
    word_t            inst_mem [DEPTH];
    logic [DEPTH-1:0] bad_mem;

    logic             bypass;
    logic             deq_valid_int;
    logic             deq_fire;
    logic             head_fire;
    logic             enq;
    logic             enq_write;
    logic [CntW:0]    inflight;
    logic             credit_ok;
    logic             req_int;
    word_t            addr_int;
    logic             accept;
    word_t            deq_pc_int;
    word_t            deq_inst_int;
    logic             deq_bad_int;

    always_comb begin
        bypass = 1'b0;
`ifdef VSCALE_FETCH_BYPASS_EN
        bypass = ~reset & ~bus.redirect & resp_pending_q & (count_q == '0);
`endif
        deq_valid_int = ~reset & ~bus.redirect & ((count_q != '0) | bypass);
        deq_fire      = deq_valid_int & bus.deq_ready;
        // A bypassed response that DX takes immediately never touches the storage.
        head_fire     = deq_fire & ~bypass;
        enq           = ~reset & resp_pending_q & ~bus.redirect;
        enq_write     = enq & ~(bypass & bus.deq_ready);

        // Reserve a slot for every outstanding response so the queue can never overflow.
        inflight  = {1'b0, count_q} + (CntW + 1)'(resp_pending_q) - (CntW + 1)'(deq_fire);
        credit_ok = inflight < DepthW;
        req_int   = ~reset & (bus.redirect | credit_ok);
        addr_int  = bus.redirect ? bus.redirect_pc : fetch_pc_q;
        accept    = req_int & ~bus.imem_wait;
    end

    always_comb begin
        fetch_pc_d     = bus.redirect ? bus.redirect_pc : fetch_pc_q;
        pc_pending_d   = pc_pending_q;
        resp_pending_d = accept;
        if (accept) begin
            fetch_pc_d   = addr_int + word_t'(4);
            pc_pending_d = addr_int;
        end

        wr_ptr_d = wr_ptr_q + PtrW'(enq_write);
        if (bus.redirect) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PtrW'(head_fire);
            count_d  = count_q + CntW'(enq_write) - CntW'(head_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q     <= RESET_PC;
            pc_pending_q   <= '0;
            resp_pending_q <= 1'b0;
            count_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            pc_pending_q   <= pc_pending_d;
            resp_pending_q <= resp_pending_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (enq_write) begin
            pc_mem[wr_ptr_q]   <= pc_pending_q;
            inst_mem[wr_ptr_q] <= bus.imem_rdata;
            bad_mem[wr_ptr_q]  <= bus.imem_badmem_e;
        end
    end

    always_comb begin
        deq_pc_int   = pc_mem[rd_ptr_q];
        deq_inst_int = inst_mem[rd_ptr_q];
        deq_bad_int  = bad_mem[rd_ptr_q];
        if (reset) begin
            deq_pc_int   = '0;
            deq_inst_int = '0;
            deq_bad_int  = 1'b0;
        end else if (bypass) begin
            deq_pc_int   = pc_pending_q;
            deq_inst_int = bus.imem_rdata;
            deq_bad_int  = bus.imem_badmem_e;
        end
    end

    assign bus.imem_req   = req_int;
    assign bus.imem_addr  = addr_int;
    assign bus.deq_valid  = deq_valid_int;
    assign bus.deq_pc     = deq_pc_int;
    assign bus.deq_inst   = deq_inst_int;
    assign bus.deq_badmem = deq_bad_int;
    assign bus.occupancy  = reset ? '0 : count_q;
endmodule

// File: tb/tb_vscale_fetch_queue.sv
// Directed bench for vscale_fetch_queue: streaming, backpressure, imem_wait, redirect, wrap/fault.
module tb_vscale_fetch_queue;
    localparam logic [31:0] InstKey = 32'h1357_9BDF;
`ifdef VSCALE_FETCH_BYPASS_EN
    localparam int Lat = 1;
`else
    localparam int Lat = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] fault_addr;
    logic [31:0] obs_pc[$];
    logic [31:0] obs_inst[$];
    logic        obs_bad[$];

    vscale_fetch_queue_if #(.XPR_LEN(32), .DEPTH(4)) bus ();

    vscale_fetch_queue #(.XPR_LEN(32), .DEPTH(4), .RESET_PC(32'h200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: log any dequeue, then play the 1-cycle-latency memory.
    task automatic cycle();
        logic        acc;
        logic [31:0] addr;
        #1;
        acc  = bus.imem_req & ~bus.imem_wait;
        addr = bus.imem_addr;
        if (bus.deq_valid & bus.deq_ready) begin
            obs_pc.push_back(bus.deq_pc);
            obs_inst.push_back(bus.deq_inst);
            obs_bad.push_back(bus.deq_badmem);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            bus.imem_rdata    = addr ^ InstKey;
            bus.imem_badmem_e = (addr == fault_addr);
        end
    endtask

    task automatic do_reset(input string tag);
        reset          = 1'b1;
        bus.redirect   = 1'b0;
        bus.imem_wait  = 1'b0;
        #1;
        check({tag, "_rst_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_rst_valid"}, 32'(bus.deq_valid), 32'd0);
        check({tag, "_rst_occ"}, 32'(bus.occupancy), 32'd0);
        cycle();
        cycle();
        reset = 1'b0;
        obs_pc.delete();
        obs_inst.delete();
        obs_bad.delete();
    endtask

    task automatic drain(input string tag, input int n, input int limit);
        for (int i = 0; i < limit && obs_pc.size() < n; i++) cycle();
        check({tag, "_count"}, 32'(obs_pc.size()), 32'(n));
    endtask

    task automatic check_seq(input string tag, input logic [31:0] base, input int n);
        for (int k = 0; k < n && k < obs_pc.size(); k++) begin
            check($sformatf("%s_pc%0d", tag, k), obs_pc[k], base + 32'(4 * k));
            check($sformatf("%s_inst%0d", tag, k), obs_inst[k], (base + 32'(4 * k)) ^ InstKey);
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = '0;
        bus.imem_wait     = 1'b0;
        bus.imem_rdata    = '0;
        bus.imem_badmem_e = 1'b0;
        bus.deq_ready     = 1'b1;
        fault_addr        = 32'h1;

        // Streaming: one fetch per cycle, first dequeue after the fixed latency.
        do_reset("s1");
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("s1_addr%0d", i), bus.imem_addr, 32'h200 + 32'(4 * i));
            check($sformatf("s1_req%0d", i), 32'(bus.imem_req), 32'd1);
            check($sformatf("s1_valid%0d", i), 32'(bus.deq_valid), 32'(i >= Lat));
            if (i == Lat) check("s1_first_pc", bus.deq_pc, 32'h200);
            cycle();
        end
        drain("s1", 4, 20);
        check_seq("s1", 32'h200, 4);

        // Backpressure: queue fills to exactly DEPTH and requests stop.
        bus.deq_ready = 1'b0;
        do_reset("s2");
        for (int i = 0; i < 8; i++) cycle();
        #1;
        check("s2_occ", 32'(bus.occupancy), 32'd4);
        check("s2_req", 32'(bus.imem_req), 32'd0);
        check("s2_valid", 32'(bus.deq_valid), 32'd1);
        check("s2_head", bus.deq_pc, 32'h200);
        bus.deq_ready = 1'b1;
        drain("s2", 8, 30);
        check_seq("s2", 32'h200, 8);

        // imem_wait stall at 0x208: address holds, no duplicates or gaps.
        do_reset("s3");
        cycle();
        cycle();
        bus.imem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("s3_hold%0d", i), bus.imem_addr, 32'h208);
            cycle();
        end
        bus.imem_wait = 1'b0;
        drain("s3", 6, 30);
        check_seq("s3", 32'h200, 6);

        // Redirect with three queued entries and one response in flight.
        bus.deq_ready = 1'b0;
        do_reset("s4");
        for (int i = 0; i < 4; i++) cycle();
        #1;
        check("s4_occ", 32'(bus.occupancy), 32'd3);
        check("s4_req_full", 32'(bus.imem_req), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h400;
        bus.deq_ready   = 1'b1;
        #1;
        check("s4_addr", bus.imem_addr, 32'h400);
        check("s4_req", 32'(bus.imem_req), 32'd1);
        check("s4_valid", 32'(bus.deq_valid), 32'd0);
        cycle();
        bus.redirect = 1'b0;
        #1;
        check("s4_occ_after", 32'(bus.occupancy), 32'd0);
        check("s4_addr_after", bus.imem_addr, 32'h404);
        drain("s4", 3, 20);
        check_seq("s4", 32'h400, 3);

        // Address wrap at 2^32 and a single faulting fetch.
        do_reset("s5");
        fault_addr      = 32'hFFFF_FFFC;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        cycle();
        bus.redirect = 1'b0;
        #1;
        check("s5_addr_fc", bus.imem_addr, 32'hFFFF_FFFC);
        cycle();
        #1;
        check("s5_addr_wrap", bus.imem_addr, 32'h0);
        drain("s5", 4, 20);
        check_seq("s5", 32'hFFFF_FFF8, 4);
        for (int k = 0; k < 4 && k < obs_bad.size(); k++)
            check($sformatf("s5_bad%0d", k), 32'(obs_bad[k]), 32'(k == 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
